// File: rtl/seg595_pkg.sv
// Shared constants and the hex-to-segment decode for the static 74HC595 display driver.
package seg595_pkg;

   localparam int         FRAME_BITS    = 14;
   localparam int         BIT_CLKS      = 4;
   localparam int         SEL_BITS      = 6;
   localparam int         SEG_BITS      = 8;
   localparam int         FAST_SIM_MAX  = 24;
   localparam logic [5:0] SEL_ALL       = 6'b111111;
   localparam logic [7:0] SEG_BLANK     = 8'hFF;

   // Common-anode, active-low segments; bit 7 is the decimal point and stays dark.
   function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
      logic [7:0] seg_code;
      case (hex)
         4'h0:    seg_code = 8'hC0;
         4'h1:    seg_code = 8'hF9;
         4'h2:    seg_code = 8'hA4;
         4'h3:    seg_code = 8'hB0;
         4'h4:    seg_code = 8'h99;
         4'h5:    seg_code = 8'h92;
         4'h6:    seg_code = 8'h82;
         4'h7:    seg_code = 8'hF8;
         4'h8:    seg_code = 8'h80;
         4'h9:    seg_code = 8'h90;
         4'hA:    seg_code = 8'h88;
         4'hB:    seg_code = 8'h83;
         4'hC:    seg_code = 8'hC6;
         4'hD:    seg_code = 8'hA1;
         4'hE:    seg_code = 8'h86;
         default: seg_code = 8'h8E;
      endcase
      return seg_code;
   endfunction

endpackage

// File: rtl/hc595_shift.sv
// Continuous serialiser for a daisy-chained 74HC595 pair: 14-bit frame, 4 clocks per bit.
module hc595_shift
   import seg595_pkg::*;
(
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   input  logic [SEG_BITS-1:0] seg,
   input  logic [SEL_BITS-1:0] sel,
   output logic                ds,
   output logic                shcp,
   output logic                stcp,
   output logic                oe
);

   localparam int               C4_W     = $clog2(BIT_CLKS);
   localparam int               BIT_W    = $clog2(FRAME_BITS);
   localparam logic [C4_W-1:0]  C4_LOAD  = '0;
   localparam logic [C4_W-1:0]  C4_RISE  = C4_W'(2);
   localparam logic [C4_W-1:0]  C4_LAST  = C4_W'(BIT_CLKS - 1);
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);

   logic [FRAME_BITS-1:0] frame;
   logic [C4_W-1:0]       cnt_4_reg;
   logic [BIT_W-1:0]      cnt_bit_reg;
   logic                  ds_reg;
   logic                  shcp_reg;
   logic                  stcp_reg;
   logic                  oe_reg;

   // Select bits go out first; segment bits follow with seg[0] shifted last.
   genvar gi;
   generate
      for (gi = 0; gi < SEL_BITS; gi++) begin : g_sel_bits
         assign frame[gi] = sel[gi];
      end
      for (gi = SEL_BITS; gi < FRAME_BITS; gi++) begin : g_seg_bits
         assign frame[gi] = seg[FRAME_BITS-1-gi];
      end
   endgenerate

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_4_reg   <= '0;
         cnt_bit_reg <= '0;
         ds_reg      <= 1'b0;
         shcp_reg    <= 1'b0;
         stcp_reg    <= 1'b0;
         oe_reg      <= 1'b1;
      end else begin
         cnt_4_reg <= (cnt_4_reg == C4_LAST) ? '0 : cnt_4_reg + C4_W'(1);
         if (cnt_4_reg == C4_LAST) begin
            cnt_bit_reg <= (cnt_bit_reg == BIT_LAST) ? '0 : cnt_bit_reg + BIT_W'(1);
         end
         if (cnt_4_reg == C4_LOAD) begin
            ds_reg <= frame[cnt_bit_reg];
         end
         // Shift clock rises two cycles after data changes, falls when the next bit loads.
         if (cnt_4_reg == C4_RISE) begin
            shcp_reg <= 1'b1;
         end else if (cnt_4_reg == C4_LOAD) begin
            shcp_reg <= 1'b0;
         end
         stcp_reg <= (cnt_bit_reg == BIT_LAST) && (cnt_4_reg == C4_LAST);
         oe_reg   <= 1'b0;
      end
   end

   assign ds   = ds_reg;
   assign shcp = shcp_reg;
   assign stcp = stcp_reg;
   assign oe   = oe_reg;

endmodule

// File: rtl/seg_static_gen.sv
// Advance tick, hex digit counter and registered segment / digit-select patterns.
// Define SEG595_FAST_SIM_EN to force a 25-clock advance interval for simulation.
module seg_static_gen
   import seg595_pkg::*;
#(
   parameter int CNT_MAX = 24_999_999
) (
   input  logic                sys_clk,
   input  logic                sys_rst_n,
   output logic [SEG_BITS-1:0] seg,
   output logic [SEL_BITS-1:0] sel
);

`ifdef SEG595_FAST_SIM_EN
   localparam int WAIT_MAX = FAST_SIM_MAX;
`else
   localparam int WAIT_MAX = CNT_MAX;
`endif
   localparam int               WAIT_W      = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_LAST   = WAIT_W'(WAIT_MAX);
   localparam logic [WAIT_W-1:0] WAIT_STROBE = WAIT_W'(WAIT_MAX - 1);

   logic [WAIT_W-1:0]   cnt_wait_reg;
   logic [3:0]          num_reg;
   logic [SEG_BITS-1:0] seg_reg;
   logic [SEL_BITS-1:0] sel_reg;
   logic                advance;

   // Strobe one cycle before the wrap so the first step lands CNT_MAX cycles after reset.
   assign advance = (cnt_wait_reg == WAIT_STROBE);

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_wait_reg <= '0;
         num_reg      <= '0;
         seg_reg      <= SEG_BLANK;
         sel_reg      <= '0;
      end else begin
         cnt_wait_reg <= (cnt_wait_reg == WAIT_LAST) ? '0 : cnt_wait_reg + WAIT_W'(1);
         if (advance) begin
            num_reg <= num_reg + 4'd1;
         end
         seg_reg <= hex_to_seg(num_reg);
         sel_reg <= SEL_ALL;
      end
   end

   assign seg = seg_reg;
   assign sel = sel_reg;

endmodule

// File: rtl/seg595_static.sv
// Board-level top: hex counter shown on all six digits through a 74HC595 pair.
// Define SEG595_FAST_SIM_EN to shorten the digit-advance interval to 25 clocks.
module seg595_static
   import seg595_pkg::*;
#(
   parameter int CNT_MAX = 24_999_999
) (
   input  logic sys_clk,
   input  logic sys_rst_n,
   output logic ds,
   output logic shcp,
   output logic stcp,
   output logic oe
);

   logic [SEG_BITS-1:0] seg;
   logic [SEL_BITS-1:0] sel;

   seg_static_gen #(
      .CNT_MAX (CNT_MAX)
   ) u_gen (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .seg       (seg),
      .sel       (sel)
   );

   hc595_shift u_shift (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .seg       (seg),
      .sel       (sel),
      .ds        (ds),
      .shcp      (shcp),
      .stcp      (stcp),
      .oe        (oe)
   );

endmodule

// File: tb/tb_seg595_static.sv
// Self-checking bench for seg595_static against a cycle-count reference model.
module tb_seg595_static;

   localparam int TB_CNT_MAX = 149;
`ifdef SEG595_FAST_SIM_EN
   localparam int EFF = 24;
`else
   localparam int EFF = TB_CNT_MAX;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic ds, shcp, stcp, oe;

   int checks = 0;
   int errors = 0;
   int k      = 0;

   logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
   logic [13:0] cap;
   int          cap_n      = 0;
   logic        shcp_prev  = 1'b0;
   logic        frame_done = 1'b0;
   logic [13:0] last_frame;
   int          last_n;

   seg595_static #(
      .CNT_MAX (TB_CNT_MAX)
   ) dut (
      .sys_clk   (clk),
      .sys_rst_n (rst_n),
      .ds        (ds),
      .shcp      (shcp),
      .stcp      (stcp),
      .oe        (oe)
   );

   always #10 clk = ~clk;

   // Digit value after s clocks since reset release.
   function automatic int num_at(input int s);
      if (s < EFF) return 0;
      return ((s - EFF) / (EFF + 1) + 1) % 16;
   endfunction

   // Frame bit b as presented by the pattern registers after s clocks.
   function automatic logic frame_bit(input int s, input int b);
      logic [7:0] sg;
      logic [5:0] sl;
      if (s == 0) begin
         sg = 8'hFF;
         sl = 6'h00;
      end else begin
         sg = seg_tab[num_at(s - 1)];
         sl = 6'h3F;
      end
      if (b < 6) return sl[b];
      return sg[13 - b];
   endfunction

   // ds after k clocks: last loaded on the clock that started the current bit slot.
   function automatic logic ds_model(input int kk);
      int j;
      if (kk < 1) return 1'b0;
      j = ((kk - 1) / 4) * 4 + 1;
      return frame_bit(j - 1, ((j - 1) / 4) % 14);
   endfunction

   function automatic logic shcp_model(input int kk);
      return (kk >= 3) && ((kk % 4 == 3) || (kk % 4 == 0));
   endfunction

   function automatic logic stcp_model(input int kk);
      return (kk >= 1) && (kk % 56 == 0);
   endfunction

   function automatic logic [13:0] frame_model(input int n);
      logic [13:0] f;
      logic [7:0]  sg;
      sg = seg_tab[n];
      for (int i = 0; i < 14; i++) f[i] = (i < 6) ? 1'b1 : sg[13 - i];
      return f;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      k++;
      if (shcp && !shcp_prev) begin
         if (cap_n < 14) cap[cap_n] = ds;
         cap_n++;
      end
      if (stcp) begin
         frame_done = 1'b1;
         last_frame = cap;
         last_n     = cap_n;
         cap_n      = 0;
      end
      shcp_prev = shcp;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n      = 1'b1;
      k          = 0;
      cap_n      = 0;
      shcp_prev  = 1'b0;
      frame_done = 1'b0;
   endtask

   // Compare a completed frame only when the digit was stable for the whole frame.
   task automatic check_frame(input string name);
      logic [13:0] exp_f;
      if (frame_done) begin
         frame_done = 1'b0;
         if (k >= 60 && num_at(k - 60) == num_at(k)) begin
            exp_f = frame_model(num_at(k));
            checks++;
            if (last_frame !== exp_f || last_n != 14) begin
               errors++;
               $display("FAIL %s k=%0d: frame %b (%0d bits) expected %b (14 bits)",
                        name, k, last_frame, last_n, exp_f);
            end else begin
               $display("frame %s k=%0d num=%0d frame=%b", name, k, num_at(k), last_frame);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #5;
      checks++;
      if ({ds, shcp, stcp, oe} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_async: ds/shcp/stcp/oe=%b expected 0001", {ds, shcp, stcp, oe});
      end
      #10;
      checks++;
      if ({ds, shcp, stcp, oe} !== 4'b0001) begin
         errors++;
         $display("FAIL reset_clocked: ds/shcp/stcp/oe=%b expected 0001", {ds, shcp, stcp, oe});
      end
      release_reset();
      step();
      checks++;
      if (oe !== 1'b0) begin
         errors++;
         $display("FAIL oe_release: oe=%b expected 0", oe);
      end
      $display("reset: released, oe=%b after first clock", oe);
   endtask

   task automatic test_shift_timing(input int ncyc);
      for (int i = 0; i < ncyc; i++) begin
         step();
         checks++;
         if (shcp !== shcp_model(k) || stcp !== stcp_model(k) || oe !== 1'b0) begin
            errors++;
            $display("FAIL shift_timing k=%0d: shcp=%b stcp=%b oe=%b expected %b %b 0",
                     k, shcp, stcp, oe, shcp_model(k), stcp_model(k));
         end
      end
      $display("shift_timing: %0d cycles up to k=%0d", ncyc, k);
   endtask

   task automatic test_stream(input string name, input int k_end);
      while (k < k_end) begin
         step();
         checks++;
         if (ds !== ds_model(k)) begin
            errors++;
            $display("FAIL %s_ds k=%0d: ds=%b expected %b", name, k, ds, ds_model(k));
         end
         check_frame(name);
      end
      $display("%s: reached k=%0d num=%0d", name, k, num_at(k));
   endtask

   task automatic test_midframe_reset();
      int off;
      int hold;
      off  = $urandom_range(0, 3);
      hold = $urandom_range(1, 5);
      for (int i = 0; i < 60 && (k % 56) != 28; i++) step();
      repeat (off) step();
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ds, shcp, stcp, oe} !== 4'b0001) begin
         errors++;
         $display("FAIL midframe_async k=%0d: ds/shcp/stcp/oe=%b expected 0001",
                  k, {ds, shcp, stcp, oe});
      end
      $display("midframe_reset: asserted at bit 7 phase %0d, hold %0d", off, hold);
      repeat (hold) @(posedge clk);
      release_reset();
      test_stream("midframe_restart", 120);
   endtask

   task automatic test_back_to_back();
      int run;
      int dly;
      for (int n = 0; n < 3; n++) begin
         run = $urandom_range(10, 200);
         dly = $urandom_range(1, 18);
         for (int i = 0; i < run; i++) begin
            step();
            checks++;
            if (ds !== ds_model(k) || shcp !== shcp_model(k)) begin
               errors++;
               $display("FAIL b2b_run k=%0d: ds=%b shcp=%b expected %b %b",
                        k, ds, shcp, ds_model(k), shcp_model(k));
            end
         end
         #dly;
         rst_n = 1'b0;
         #1;
         checks++;
         if (oe !== 1'b1 || shcp !== 1'b0) begin
            errors++;
            $display("FAIL b2b_reset: oe=%b shcp=%b expected 1 0", oe, shcp);
         end
         repeat ($urandom_range(1, 3)) @(posedge clk);
         release_reset();
         step();
         checks++;
         if (oe !== 1'b0 || ds !== 1'b0) begin
            errors++;
            $display("FAIL b2b_release: oe=%b ds=%b expected 0 0", oe, ds);
         end
         $display("back_to_back %0d: run %0d, reset delay %0d", n, run, dly);
      end
   endtask

   initial begin
      test_reset();
      test_shift_timing(120);
      test_stream("advance", 2 * EFF + 1 + 120);
      test_stream("wrap", 17 * (EFF + 1) + 120);
      test_midframe_reset();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
